// File: rtl/reset_seq_defs.vh
// Shared definitions for reset_seq: FSM encodings, a width helper and the
// per-channel delay field extractor. Included inside the module body.
localparam logic [2:0] ST_HOLD = 3'd0;
localparam logic [2:0] ST_DLY  = 3'd1;
localparam logic [2:0] ST_RDY  = 3'd2;
localparam logic [2:0] ST_DONE = 3'd3;
localparam logic [2:0] ST_ERR  = 3'd4;

function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
endfunction

`define RS_DLY_FIELD(vec, i, w) vec[(i)*(w) +: (w)]

// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: releases channel resets in index order with
// per-channel delays, optional ready handshakes with timeout, and restart.
module reset_seq #(
    parameter int                        NUM_CH      = 3,
    parameter int                        CNT_W       = 8,
    parameter int                        HOLD_CYC    = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   DLY_CH      = {8'd16, 8'd16, 8'd0},
    parameter logic [NUM_CH-1:0]         WAIT_RDY    = '0,
    parameter int                        TIMEOUT_CYC = 4096
) (
    input  logic                                          clk,
    input  logic                                          rstn_glbl,
    input  logic                                          i_soft_rst,
    input  logic [NUM_CH-1:0]                             i_ch_rdy,
    output logic [NUM_CH-1:0]                             o_rst,
    output logic [NUM_CH-1:0]                             o_rstn,
    output logic                                          o_seq_done,
    output logic                                          o_err,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_err_ch,
    output logic                                          o_rdy_lost
);
    `include "reset_seq_defs.vh"

    localparam int IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int HOLD_W = clog2(HOLD_CYC);
    localparam int CNT_WW = (CNT_W > HOLD_W) ? CNT_W : HOLD_W;
    localparam int TCNT_W = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_WW-1:0] HOLD_LAST = CNT_WW'(HOLD_CYC - 1);
    localparam logic [TCNT_W-1:0] TOUT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(NUM_CH - 1);

    logic [2:0]        state, state_nxt;
    logic [CNT_WW-1:0] cnt, cnt_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [CNT_W-1:0]  dly_cur;
    logic              release_ch, advance, timeout, lost;

    logic [NUM_CH-1:0] rst_nxt;
    logic              done_nxt, err_nxt, lost_nxt;
    logic [IDX_W-1:0]  err_ch_nxt;

    assign dly_cur = `RS_DLY_FIELD(DLY_CH, int'(idx), CNT_W);

    always_ff @(posedge clk) begin
        if (!rstn_glbl) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            tcnt       <= '0;
            idx        <= '0;
            o_rst      <= '1;
            o_rstn     <= '0;
            o_seq_done <= 1'b0;
            o_err      <= 1'b0;
            o_err_ch   <= '0;
            o_rdy_lost <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tcnt       <= tcnt_nxt;
            idx        <= idx_nxt;
            o_rst      <= rst_nxt;
            o_rstn     <= ~rst_nxt;
            o_seq_done <= done_nxt;
            o_err      <= err_nxt;
            o_err_ch   <= err_ch_nxt;
            o_rdy_lost <= lost_nxt;
        end
    end

    // Soft restart overrides every FSM transition, including ready/timeout.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tcnt_nxt   = tcnt;
        idx_nxt    = idx;
        release_ch = 1'b0;
        advance    = 1'b0;
        timeout    = 1'b0;
        lost       = 1'b0;
        if (i_soft_rst) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
            tcnt_nxt  = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = ST_DLY;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_DLY: begin
                    if (cnt == CNT_WW'(dly_cur)) begin
                        release_ch = 1'b1;
                        if (WAIT_RDY[idx]) begin
                            state_nxt = ST_RDY;
                            cnt_nxt   = '0;
                            tcnt_nxt  = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RDY: begin
                    if (i_ch_rdy[idx]) begin
                        advance = 1'b1;
                    end else if (tcnt == TOUT_LAST) begin
                        state_nxt = ST_ERR;
                        timeout   = 1'b1;
                        tcnt_nxt  = '0;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (|(WAIT_RDY & ~i_ch_rdy)) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        lost      = 1'b1;
                    end
                end
                ST_ERR: ;
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
            if (advance) begin
                cnt_nxt  = '0;
                tcnt_nxt = '0;
                if (idx == LAST_CH) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DLY;
                    idx_nxt   = idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rst_nxt    = o_rst;
        err_nxt    = o_err;
        err_ch_nxt = o_err_ch;
        lost_nxt   = o_rdy_lost;
        done_nxt   = (state_nxt == ST_DONE);
        if (i_soft_rst) begin
            rst_nxt  = '1;
            err_nxt  = 1'b0;
            lost_nxt = 1'b0;
        end else if (lost) begin
            rst_nxt  = '1;
            lost_nxt = 1'b1;
        end else if (timeout) begin
            rst_nxt[idx] = 1'b1;
            err_nxt      = 1'b1;
            err_ch_nxt   = idx;
        end else if (release_ch) begin
            rst_nxt[idx] = 1'b0;
        end
    end

endmodule
